// File: rtl/hvl_stream_deframer_pkg.sv
// Shared types for the HVL stream deframer.
// Holds the header layout, error codes, FSM states and buffer beat.
package hvl_stream_pkg;

   localparam logic [7:0] HVL_STREAM_MAGIC = 8'hA5;

   typedef struct packed {
      logic [7:0] magic;
      logic [7:0] tag;
      logic [7:0] rsvd;
      logic [7:0] len;
   } hdr_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_MAGIC = 2'd1,
      ERR_LEN   = 2'd2,
      ERR_CSUM  = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_PAYLOAD,
      ST_CSUM
   } state_t;

   // 42-bit buffer entry: payload word plus sideband
   typedef struct packed {
      logic [31:0] dat;
      logic        sop;
      logic        eop;
      logic [7:0]  tag;
   } beat_t;

endpackage

// File: rtl/hvl_stream_deframer_if.sv
// Word-stream bundle between the fifo bridge, deframer and consumer.
// master = stimulus/upstream side, slave = deframer side.
interface hvl_stream_deframer_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_dat;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_dat;
   logic        out_sop;
   logic        out_eop;
   logic [7:0]  out_tag;
   logic        err_valid;
   logic [1:0]  err_code;
   logic [15:0] pkt_count;

   modport master (
      output in_valid, in_dat, out_ready,
      input  in_ready, out_valid, out_dat, out_sop,
      input  out_eop, out_tag, err_valid, err_code,
      input  pkt_count
   );

   modport slave (
      input  in_valid, in_dat, out_ready,
      output in_ready, out_valid, out_dat, out_sop,
      output out_eop, out_tag, err_valid, err_code,
      output pkt_count
   );

endinterface

// File: rtl/hvl_stream_deframer_skid2.sv
// 2-entry ready/valid FIFO for deframer payload beats.
// Ports: clock/reset, push_i/din_i, pop_i, valid_o/dout_o, cnt_o.
module hvl_stream_skid2 (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push_i,
   input  hvl_stream_pkg::beat_t din_i,
   input  logic                 pop_i,
   output logic                 valid_o,
   output hvl_stream_pkg::beat_t dout_o,
   output logic [1:0]           cnt_o
);
   import hvl_stream_pkg::*;

   beat_t      mem_q [2];
   logic       wr_q;
   logic       rd_q;
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic       push;
   logic       pop;

   assign push  = push_i && (cnt_q != 2'd2);
   assign pop   = pop_i && (cnt_q != 2'd0);
   assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clock) begin
      if (!reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         cnt_q <= cnt_d;
      end
   end

   // zero the head when empty so stale data never shows
   assign valid_o = (cnt_q != 2'd0);
   assign dout_o  = valid_o ? mem_q[rd_q] : '0;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/hvl_stream_deframer.sv
// Parses header/payload/checksum frames from the HVL word stream.
// Ports: clock, reset (active-low sync), bus (slave modport).
module hvl_stream_deframer #(
   parameter int Tmaxlen = 16
) (
   input logic                  clock,
   input logic                  reset,
   hvl_stream_deframer_if.slave bus
);
   import hvl_stream_pkg::*;

   localparam logic [7:0] MAXLEN = 8'(Tmaxlen);

   state_t      state_q;
   logic [7:0]  tag_q;
   logic [7:0]  len_q;
   logic [7:0]  idx_q;
   logic [31:0] csum_q;
   logic        run_q;
   logic        err_valid_q;
   err_code_t   err_code_q;
   logic [15:0] pkt_q;

   hdr_t       hdr;
   beat_t      beat_d;
   beat_t      head;
   logic [1:0] fcnt;
   logic       fvalid;
   logic       in_ready_d;
   logic       acc;
   logic       push;
   logic       last;
   logic       len_bad;

   assign hdr     = bus.in_dat;
   assign len_bad = (hdr.len == 8'd0) || (hdr.len > MAXLEN);
   assign last    = (idx_q == len_q - 8'd1);

   // run_q keeps in_ready low until the first edge out of reset
   always_comb begin
      in_ready_d = 1'b0;
      if (run_q && reset) begin
         if (state_q == ST_PAYLOAD) in_ready_d = (fcnt != 2'd2);
         else                       in_ready_d = 1'b1;
      end
   end

   assign acc  = bus.in_valid && in_ready_d;
   assign push = acc && (state_q == ST_PAYLOAD);

   always_comb begin
      beat_d     = '0;
      beat_d.dat = bus.in_dat;
      beat_d.sop = (idx_q == 8'd0);
      beat_d.eop = last;
      beat_d.tag = tag_q;
   end

   hvl_stream_skid2 u_buf (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push),
      .din_i   (beat_d),
      .pop_i   (bus.out_ready),
      .valid_o (fvalid),
      .dout_o  (head),
      .cnt_o   (fcnt)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_HDR;
         tag_q       <= 8'd0;
         len_q       <= 8'd0;
         idx_q       <= 8'd0;
         csum_q      <= 32'd0;
         run_q       <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         pkt_q       <= 16'd0;
      end else begin
         run_q       <= 1'b1;
         err_valid_q <= 1'b0;
         unique case (state_q)
            ST_HDR: if (acc) begin
               if (hdr.magic != HVL_STREAM_MAGIC) begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= ERR_MAGIC;
               end else if (len_bad) begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= ERR_LEN;
               end else begin
                  tag_q   <= hdr.tag;
                  len_q   <= hdr.len;
                  idx_q   <= 8'd0;
                  csum_q  <= hdr;
                  state_q <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: if (acc) begin
               csum_q <= csum_q ^ bus.in_dat;
               idx_q  <= idx_q + 8'd1;
               if (last) state_q <= ST_CSUM;
            end
            ST_CSUM: if (acc) begin
               if (bus.in_dat == csum_q) begin
                  pkt_q <= pkt_q + 16'd1;
               end else begin
                  err_valid_q <= 1'b1;
                  err_code_q  <= ERR_CSUM;
               end
               state_q <= ST_HDR;
            end
            default: state_q <= ST_HDR;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_d;
   assign bus.out_valid = fvalid;
   assign bus.out_dat   = head.dat;
   assign bus.out_sop   = head.sop;
   assign bus.out_eop   = head.eop;
   assign bus.out_tag   = head.tag;
   assign bus.err_valid = err_valid_q;
   assign bus.err_code  = err_code_q;
   assign bus.pkt_count = pkt_q;

endmodule
